// File: rtl/atoi_radix.sv
// atoi_radix: reads a NUL/space-terminated token from byte RAM and converts it in base 2..36, one char per clock after a one-cycle prime.
// No backpressure (start is ignored while bsy); optional $/%/# base prefixes are enabled by `define ATOI_PREFIX_EN.
module atoi_radix #(
  parameter int ASZ = 17,
  parameter int DSZ = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [5:0]     base,
  input  logic [ASZ-1:0] tib,
  output logic [ASZ-1:0] ai,
  input  logic [7:0]     ch,
  output logic           bsy,
  output logic           done,
  output logic           ok,
  output logic           ov,
  output logic [DSZ-1:0] vo
);

  typedef enum logic [2:0] {IDLE, PRIME, LEAD, SIGN, DIG} state_t;

  state_t         state_q, state_d;
  logic [ASZ-1:0] ai_q, ai_d;
  logic [5:0]     base_q, base_d;
  logic [DSZ-1:0] acc_q, acc_d;
  logic [DSZ-1:0] vo_q, vo_d;
  logic           neg_q, neg_d;
  logic           dig_q, dig_d;
  logic           ov_q, ov_d;
  logic           ok_q, ok_d;
  logic           done_q, done_d;
  logic           bsy_q, bsy_d;
  logic           bad_q, bad_d;

  logic           base_ok, in_scan, is_sp, is_nul, is_minus, is_plus, is_pfx;
  logic           is_num, is_low, is_upp, is_dig;
  logic           skip, sign_ok, pfx, eval, step, term;
  logic [5:0]     dval;
  logic [DSZ+5:0] prod;

  assign base_ok  = (base >= 6'd2) && (base <= 6'd36);
  assign in_scan  = (state_q == LEAD) || (state_q == SIGN) || (state_q == DIG);
  assign is_sp    = (ch == 8'h20);
  assign is_nul   = (ch == 8'h00);
  assign is_minus = (ch == 8'h2D);
  assign is_plus  = (ch == 8'h2B);
`ifdef ATOI_PREFIX_EN
  assign is_pfx   = (ch == 8'h24) || (ch == 8'h25) || (ch == 8'h23);
`else
  assign is_pfx   = 1'b0;
`endif

  assign is_num = (ch >= 8'h30) && (ch <= 8'h39);
  assign is_low = (ch >= 8'h61) && (ch <= 8'h7A);
  assign is_upp = (ch >= 8'h41) && (ch <= 8'h5A);
  assign is_dig = is_num || is_low || is_upp;

  // Low six bits of the ASCII code are enough to recover the digit value.
  always_comb begin
    dval = 6'd0;
    if (is_num)      dval = ch[5:0] - 6'd48;
    else if (is_low) dval = ch[5:0] - 6'd23;
    else if (is_upp) dval = ch[5:0] + 6'd9;
  end

  assign prod = ({6'd0, acc_q} * {{DSZ{1'b0}}, base_q}) + {{DSZ{1'b0}}, dval};

  assign skip    = (state_q == LEAD) && is_sp;
  assign sign_ok = ((state_q == LEAD) || (state_q == SIGN)) && (is_minus || is_plus);
  assign pfx     = (state_q == LEAD) && is_pfx;
  assign eval    = in_scan && !skip && !sign_ok && !pfx;
  assign step    = eval && is_dig && (dval < base_q);
  assign term    = eval && !(is_dig && (dval < base_q));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ai_q    <= '0;
      base_q  <= 6'd0;
      acc_q   <= '0;
      vo_q    <= '0;
      neg_q   <= 1'b0;
      dig_q   <= 1'b0;
      ov_q    <= 1'b0;
      ok_q    <= 1'b0;
      done_q  <= 1'b0;
      bsy_q   <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ai_q    <= ai_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      vo_q    <= vo_d;
      neg_q   <= neg_d;
      dig_q   <= dig_d;
      ov_q    <= ov_d;
      ok_q    <= ok_d;
      done_q  <= done_d;
      bsy_q   <= bsy_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start && !bad_q && base_ok) state_d = PRIME;
      PRIME:   state_d = LEAD;
      default: begin
        if (term)                 state_d = IDLE;
        else if (pfx)             state_d = SIGN;
        else if (sign_ok || step) state_d = DIG;
      end
    endcase
  end

  always_comb begin
    ai_d   = ai_q;
    base_d = base_q;
    acc_d  = acc_q;
    vo_d   = vo_q;
    neg_d  = neg_q;
    dig_d  = dig_q;
    ov_d   = ov_q;
    ok_d   = ok_q;
    done_d = 1'b0;
    bsy_d  = bsy_q;
    bad_d  = 1'b0;
    if (state_q == IDLE) begin
      // A rejected base reports one cycle after the start that carried it.
      if (bad_q) begin
        done_d = 1'b1;
        ok_d   = 1'b0;
        ov_d   = 1'b0;
        vo_d   = '0;
      end else if (start) begin
        if (base_ok) begin
          ai_d   = tib;
          base_d = base;
          acc_d  = '0;
          neg_d  = 1'b0;
          dig_d  = 1'b0;
          ov_d   = 1'b0;
          ok_d   = 1'b0;
          bsy_d  = 1'b1;
        end else begin
          bad_d  = 1'b1;
        end
      end
    end
    if (state_q == PRIME || (in_scan && !term)) ai_d = ai_q + ASZ'(1);
    if (sign_ok && is_minus) neg_d = 1'b1;
`ifdef ATOI_PREFIX_EN
    if (pfx) base_d = (ch == 8'h24) ? 6'd16 : (ch == 8'h25) ? 6'd2 : 6'd10;
`endif
    if (step) begin
      acc_d = prod[DSZ-1:0];
      dig_d = 1'b1;
      if (|prod[DSZ+5:DSZ]) ov_d = 1'b1;
    end
    if (term) begin
      ok_d   = (is_nul || is_sp) && dig_q;
      vo_d   = neg_q ? ({DSZ{1'b0}} - acc_q) : acc_q;
      done_d = 1'b1;
      bsy_d  = 1'b0;
    end
  end

  assign ai   = ai_q;
  assign bsy  = bsy_q;
  assign done = done_q;
  assign ok   = ok_q;
  assign ov   = ov_q;
  assign vo   = vo_q;

endmodule

// File: tb/tb_atoi_radix.sv
// Directed-vector bench for atoi_radix: byte RAM model with one-cycle read latency.
module tb_atoi_radix;
  localparam int ASZ = 17;
  localparam int DSZ = 32;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic [5:0]     base = 6'd0;
  logic [ASZ-1:0] tib = '0;
  logic [ASZ-1:0] ai;
  logic [7:0]     ch;
  logic           bsy, done, ok, ov;
  logic [DSZ-1:0] vo;

  logic [7:0] mem [0:4095];
  int nvec = 0;
  int nbad = 0;

  atoi_radix #(.ASZ(ASZ), .DSZ(DSZ)) dut (
    .clk(clk), .rst(rst), .start(start), .base(base), .tib(tib),
    .ai(ai), .ch(ch), .bsy(bsy), .done(done), .ok(ok), .ov(ov), .vo(vo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) ch <= mem[ai[11:0]];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    if (obs !== exp) begin
      nbad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic load(input int a, input string s, input logic [7:0] t);
    for (int i = 0; i < s.len(); i++) mem[12'(a + i)] = s[i];
    mem[12'(a + s.len())] = t;
  endtask

  // inj>0 pulses a competing start after edge E(inj)
  task automatic conv(input string tag, input logic [5:0] b, input logic [ASZ-1:0] t,
                      input int inj, input int e_edge, input logic e_ok, input logic e_ov,
                      input logic [DSZ-1:0] e_vo, input logic [ASZ-1:0] e_ai);
    int n;
    int nb;
    logic [ASZ-1:0] ai0;
    n  = 0;
    nb = 0;
    ai0 = (e_edge == 1) ? e_ai : t;
    @(negedge clk);
    start = 1'b1; base = b; tib = t;
    @(posedge clk); #1;
    start = 1'b0; base = 6'd0; tib = '0;
    chk({tag, ".ai_e0"}, 64'(ai), 64'(ai0));
    chk({tag, ".bsy_e0"}, 64'(bsy), 64'(e_edge != 1));
    while (n < 60) begin
      if (inj != 0 && n == inj) begin
        start = 1'b1; base = 6'd10; tib = 17'h100;
      end
      @(posedge clk); #1;
      start = 1'b0; base = 6'd0; tib = '0;
      n++;
      if (done === 1'b1) break;
      if (bsy === 1'b1) nb++;
    end
    chk({tag, ".done"}, 64'(done), 64'd1);
    chk({tag, ".edge"}, 64'(n), 64'(e_edge));
    chk({tag, ".ok"}, 64'(ok), 64'(e_ok));
    chk({tag, ".ov"}, 64'(ov), 64'(e_ov));
    chk({tag, ".vo"}, 64'(vo), 64'(e_vo));
    chk({tag, ".ai"}, 64'(ai), 64'(e_ai));
    chk({tag, ".bsy_end"}, 64'(bsy), 64'd0);
    chk({tag, ".bsy_cnt"}, 64'(nb), 64'(e_edge - 1));
    @(posedge clk); #1;
    chk({tag, ".pulse"}, 64'(done), 64'd0);
    chk({tag, ".hold_vo"}, 64'(vo), 64'(e_vo));
    chk({tag, ".hold_ok"}, 64'(ok), 64'(e_ok));
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    for (int i = 0; i < 4096; i++) mem[i] = 8'h00;
    load(32'h100, "123", 8'h00);
    load(32'h200, "  -1aF", 8'h20);
    load(32'h240, "12x4", 8'h00);
    load(32'h260, "-", 8'h00);
    load(32'h280, "19", 8'h00);
    load(32'h2A0, "4294967296", 8'h00);
    load(32'h2C0, "4294967295", 8'h00);
    load(32'h2E0, "$-FF", 8'h00);
    load(32'h320, "55", 8'h00);
    load(32'h340, "zZ", 8'h00);
    load(32'h360, "-101", 8'h00);
    load(32'h380, "-0", 8'h00);
    load(32'h3A0, "7", 8'h00);
    load(32'h3C0, "", 8'h00);
    load(32'h300, "98765", 8'h00);

    @(posedge clk); #1;
    chk("rst.ai", 64'(ai), 64'd0);
    chk("rst.bsy", 64'(bsy), 64'd0);
    chk("rst.done", 64'(done), 64'd0);
    chk("rst.ok", 64'(ok), 64'd0);
    chk("rst.ov", 64'(ov), 64'd0);
    chk("rst.vo", 64'(vo), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    conv("dec123",  6'd10, 17'h100, 0, 5,  1'b1, 1'b0, 32'd123,       17'h104);
    conv("base1",   6'd1,  17'h500, 0, 1,  1'b0, 1'b0, 32'd0,         17'h104);
    conv("hex",     6'd16, 17'h200, 0, 8,  1'b1, 1'b0, 32'hFFFFFE51,  17'h207);
    conv("bad_x",   6'd10, 17'h240, 0, 4,  1'b0, 1'b0, 32'd12,        17'h243);
    conv("minus",   6'd10, 17'h260, 0, 3,  1'b0, 1'b0, 32'd0,         17'h262);
    conv("oct9",    6'd8,  17'h280, 0, 3,  1'b0, 1'b0, 32'd1,         17'h282);
    conv("ovf",     6'd10, 17'h2A0, 0, 12, 1'b1, 1'b1, 32'd0,         17'h2AB);
    conv("max",     6'd10, 17'h2C0, 0, 12, 1'b1, 1'b0, 32'hFFFFFFFF,  17'h2CB);
`ifdef ATOI_PREFIX_EN
    conv("pfx",     6'd10, 17'h2E0, 0, 6,  1'b1, 1'b0, 32'hFFFFFF01,  17'h2E5);
`else
    conv("pfx",     6'd10, 17'h2E0, 0, 2,  1'b0, 1'b0, 32'd0,         17'h2E1);
`endif
    conv("busy_st", 6'd10, 17'h320, 2, 4,  1'b1, 1'b0, 32'd55,        17'h323);
    conv("b36",     6'd36, 17'h340, 0, 4,  1'b1, 1'b0, 32'd1295,      17'h343);
    conv("bin_neg", 6'd2,  17'h360, 0, 6,  1'b1, 1'b0, 32'hFFFFFFFB,  17'h365);
    conv("negzero", 6'd16, 17'h380, 0, 4,  1'b1, 1'b0, 32'd0,         17'h383);
    conv("empty",   6'd10, 17'h3C0, 0, 2,  1'b0, 1'b0, 32'd0,         17'h3C1);
    conv("bin_neg2",6'd2,  17'h360, 0, 6,  1'b1, 1'b0, 32'hFFFFFFFB,  17'h365);

    @(negedge clk);
    start = 1'b1; base = 6'd10; tib = 17'h300;
    @(posedge clk); #1;
    start = 1'b0; base = 6'd0; tib = '0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort.ai", 64'(ai), 64'd0);
    chk("abort.bsy", 64'(bsy), 64'd0);
    chk("abort.done", 64'(done), 64'd0);
    chk("abort.ok", 64'(ok), 64'd0);
    chk("abort.ov", 64'(ov), 64'd0);
    chk("abort.vo", 64'(vo), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen++;
    end
    chk("abort.nodone", 64'(seen), 64'd0);
    conv("after_rst", 6'd10, 17'h3A0, 0, 3, 1'b1, 1'b0, 32'd7, 17'h3A2);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
